// File: rtl/ins_fetch_queue_pkg.sv
// Shared constants and helpers for the instruction-fetch queue.
package ins_fetch_queue_pkg;

  localparam logic [31:0] INST_NOP         = 32'h0000_0013;
  localparam int          FQ_DEPTH_DEFAULT = 4;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/ins_fetch_queue_if.sv
// Fetch-side handshake (PC/ROM) and issue-side bus (to if_id) of the fetch queue.
interface ins_fetch_queue_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic [AW-1:0] pc_addr_i;
  logic [DW-1:0] rom_inst_i;
  logic          rom_valid_i;
  logic          fetch_ready_o;
  logic [AW-1:0] inst_addr_o;
  logic [DW-1:0] inst_o;
  logic          inst_valid_o;

  modport master (
    output pc_addr_i, rom_inst_i, rom_valid_i,
    input  fetch_ready_o, inst_addr_o, inst_o, inst_valid_o
  );

  modport slave (
    input  pc_addr_i, rom_inst_i, rom_valid_i,
    output fetch_ready_o, inst_addr_o, inst_o, inst_valid_o
  );
endinterface

// File: rtl/ins_fetch_queue_fifo.sv
// Synchronous power-of-two FIFO with push/pop/flush and a separate occupancy counter.
module fq_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  logic [W-1:0]                 wdata_i,
  output logic [W-1:0]                 rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == CW'(0));

  // Payload storage; left unreset, never observed while the slot is empty.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointer and occupancy next-state; flush discards everything still queued.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = CW'(0);
    end else begin
      if (push_i) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= PW'(0);
      rd_ptr_q <= PW'(0);
      count_q  <= CW'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/ins_fetch_queue.sv
// Instruction-fetch stage: prefetch FIFO plus registered issue stage with bypass,
// stall hold and jump flush; NOPs are issued whenever nothing valid is available.
module ins_fetch_queue
  import ins_fetch_queue_pkg::*;
#(
  parameter int            DW       = 32,
  parameter int            AW       = 32,
  parameter int            DEPTH    = FQ_DEPTH_DEFAULT,
  parameter logic [DW-1:0] NOP_INST = DW'(INST_NOP)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       jump_en_i,
  input  logic                       hold_flag_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  ins_fetch_queue_if.slave           bus
);
  logic [AW+DW-1:0] head_s;
  logic             full_s, empty_s;
  logic             wr_s, adv_s, pop_s, push_s, bypass_s;

  logic [DW-1:0]    inst_q, inst_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic             vld_q,  vld_d;

  // Ready depends only on the registered count, so a full queue refuses even on a pop cycle.
  assign wr_s     = bus.rom_valid_i & ~full_s & ~jump_en_i;
  assign adv_s    = ~hold_flag_i & ~jump_en_i;
  assign pop_s    = adv_s & ~empty_s;
  assign bypass_s = adv_s & empty_s & wr_s;
  assign push_s   = wr_s & ~bypass_s;

  assign bus.fetch_ready_o = ~full_s;
  assign bus.inst_o        = inst_q;
  assign bus.inst_addr_o   = addr_q;
  assign bus.inst_valid_o  = vld_q;

  fq_fifo #(
    .W     (AW + DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .flush_i (jump_en_i),
    .wdata_i ({bus.pc_addr_i, bus.rom_inst_i}),
    .rdata_o (head_s),
    .count_o (count_o),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // Issue-stage select: jump clears, advance takes FIFO head then bypass, hold keeps.
  always_comb begin
    inst_d = inst_q;
    addr_d = addr_q;
    vld_d  = vld_q;
    if (jump_en_i) begin
      inst_d = NOP_INST;
      addr_d = AW'(0);
      vld_d  = 1'b0;
    end else if (adv_s) begin
      if (!empty_s) begin
        addr_d = head_s[AW+DW-1:DW];
        inst_d = head_s[DW-1:0];
        vld_d  = 1'b1;
      end else if (wr_s) begin
        addr_d = bus.pc_addr_i;
        inst_d = bus.rom_inst_i;
        vld_d  = 1'b1;
      end else begin
        inst_d = NOP_INST;
        addr_d = AW'(0);
        vld_d  = 1'b0;
      end
    end else begin
      inst_d = inst_q;
      addr_d = addr_q;
      vld_d  = vld_q;
    end
  end

  // Issue-stage registers toward if_id.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_q <= NOP_INST;
      addr_q <= AW'(0);
      vld_q  <= 1'b0;
    end else begin
      inst_q <= inst_d;
      addr_q <= addr_d;
      vld_q  <= vld_d;
    end
  end
endmodule

// File: tb/tb_ins_fetch_queue.sv
// Self-checking bench: DEPTH=2/4/8 instances share stimulus; each is compared
// against a list-based reference model of the fetch-queue rules.
module tb_ins_fetch_queue;
  import ins_fetch_queue_pkg::*;

  localparam int D0 = 2;
  localparam int D1 = FQ_DEPTH_DEFAULT;
  localparam int D2 = 8;

  if (!(is_pow2(D0) && D0 >= 2 && is_pow2(D1) && D1 >= 2 && is_pow2(D2) && D2 >= 2)) begin : g_depth_bad
    $fatal(1, "DEPTH must be a power of two and at least 2");
  end

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        jmp = 1'b0;
  logic        hld = 1'b0;
  logic [1:0]  c0;
  logic [2:0]  c1;
  logic [3:0]  c2;

  ins_fetch_queue_if #(.DW(32), .AW(32)) bus0 ();
  ins_fetch_queue_if #(.DW(32), .AW(32)) bus1 ();
  ins_fetch_queue_if #(.DW(32), .AW(32)) bus2 ();

  ins_fetch_queue #(.DEPTH(D0)) u_d0 (.clk(clk), .rst(rst), .jump_en_i(jmp), .hold_flag_i(hld), .count_o(c0), .bus(bus0));
  ins_fetch_queue #(.DEPTH(D1)) u_d1 (.clk(clk), .rst(rst), .jump_en_i(jmp), .hold_flag_i(hld), .count_o(c1), .bus(bus1));
  ins_fetch_queue #(.DEPTH(D2)) u_d2 (.clk(clk), .rst(rst), .jump_en_i(jmp), .hold_flag_i(hld), .count_o(c2), .bus(bus2));

  always #5 clk = ~clk;

  logic [31:0] o_inst [3];
  logic [31:0] o_addr [3];
  logic        o_vld  [3];
  logic        o_rdy  [3];
  logic [3:0]  o_cnt  [3];
  assign o_inst[0] = bus0.inst_o;      assign o_inst[1] = bus1.inst_o;      assign o_inst[2] = bus2.inst_o;
  assign o_addr[0] = bus0.inst_addr_o; assign o_addr[1] = bus1.inst_addr_o; assign o_addr[2] = bus2.inst_addr_o;
  assign o_vld[0]  = bus0.inst_valid_o; assign o_vld[1] = bus1.inst_valid_o; assign o_vld[2] = bus2.inst_valid_o;
  assign o_rdy[0]  = bus0.fetch_ready_o; assign o_rdy[1] = bus1.fetch_ready_o; assign o_rdy[2] = bus2.fetch_ready_o;
  assign o_cnt[0]  = 4'(c0); assign o_cnt[1] = 4'(c1); assign o_cnt[2] = 4'(c2);

  // Reference model: each queue is a list with the head at index 0.
  int          dep [3] = '{D0, D1, D2};
  logic [63:0] mq  [3][8];
  int          mcnt [3];
  logic [31:0] m_inst [3];
  logic [31:0] m_addr [3];
  logic        m_vld  [3];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mcnt[k]   = 0;
      m_inst[k] = INST_NOP;
      m_addr[k] = 32'h0;
      m_vld[k]  = 1'b0;
    end
  endtask

  task automatic model_step(input logic rv, input logic j, input logic h,
                            input logic [31:0] pc, input logic [31:0] ins);
    for (int k = 0; k < 3; k++) begin
      bit wr;
      wr = rv && (mcnt[k] < dep[k]) && !j;
      if (j) begin
        mcnt[k]   = 0;
        m_inst[k] = INST_NOP;
        m_addr[k] = 32'h0;
        m_vld[k]  = 1'b0;
      end else if (!h) begin
        if (mcnt[k] > 0) begin
          m_addr[k] = mq[k][0][63:32];
          m_inst[k] = mq[k][0][31:0];
          m_vld[k]  = 1'b1;
          for (int i = 0; i < 7; i++) mq[k][i] = mq[k][i+1];
          mcnt[k]--;
          if (wr) begin
            mq[k][mcnt[k]] = {pc, ins};
            mcnt[k]++;
          end
        end else if (wr) begin
          m_addr[k] = pc;
          m_inst[k] = ins;
          m_vld[k]  = 1'b1;
        end else begin
          m_inst[k] = INST_NOP;
          m_addr[k] = 32'h0;
          m_vld[k]  = 1'b0;
        end
      end else if (wr) begin
        mq[k][mcnt[k]] = {pc, ins};
        mcnt[k]++;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s.d%0d.inst", tag, dep[k]),  64'(o_inst[k]), 64'(m_inst[k]));
      chk($sformatf("%s.d%0d.addr", tag, dep[k]),  64'(o_addr[k]), 64'(m_addr[k]));
      chk($sformatf("%s.d%0d.valid", tag, dep[k]), 64'(o_vld[k]),  64'(m_vld[k]));
      chk($sformatf("%s.d%0d.count", tag, dep[k]), 64'(o_cnt[k]),  64'(mcnt[k]));
      chk($sformatf("%s.d%0d.ready", tag, dep[k]), 64'(o_rdy[k]),  64'(mcnt[k] != dep[k]));
    end
  endtask

  // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
  task automatic cyc(input string tag, input logic rv, input logic j, input logic h, input logic [31:0] pc);
    logic [31:0] ins;
    ins = $urandom;
    bus0.rom_valid_i = rv; bus1.rom_valid_i = rv; bus2.rom_valid_i = rv;
    bus0.pc_addr_i   = pc; bus1.pc_addr_i   = pc; bus2.pc_addr_i   = pc;
    bus0.rom_inst_i  = ins; bus1.rom_inst_i = ins; bus2.rom_inst_i = ins;
    jmp = j;
    hld = h;
    model_step(rv, j, h, pc, ins);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [31:0] pc;
    bus0.rom_valid_i = 1'b0; bus1.rom_valid_i = 1'b0; bus2.rom_valid_i = 1'b0;
    bus0.pc_addr_i = 32'h0;  bus1.pc_addr_i = 32'h0;  bus2.pc_addr_i = 32'h0;
    bus0.rom_inst_i = 32'h0; bus1.rom_inst_i = 32'h0; bus2.rom_inst_i = 32'h0;
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b1;
    cyc("idle", 1'b0, 1'b0, 1'b0, 32'h0);

    // Reset then stream through the bypass path.
    for (int i = 0; i < 3; i++) begin
      cyc("stream", 1'b1, 1'b0, 1'b0, 32'(i * 4));
      chk("stream.addr", 64'(o_addr[1]), 64'(i * 4));
      chk("stream.count", 64'(o_cnt[1]), 64'd0);
    end

    // Hold fill, then release and drain in order.
    for (int i = 0; i < 6; i++) cyc("hold_fill", 1'b1, 1'b0, 1'b1, 32'h10 + 32'(i * 4));
    chk("hold_fill.count", 64'(o_cnt[1]), 64'd4);
    chk("hold_fill.ready", 64'(o_rdy[1]), 64'd0);
    chk("hold_fill.frozen", 64'(o_addr[1]), 64'h8);
    for (int i = 0; i < 4; i++) begin
      cyc("drain", 1'b0, 1'b0, 1'b0, 32'h0);
      chk("drain.addr", 64'(o_addr[1]), 64'h10 + 64'(i * 4));
    end

    // Full with simultaneous pop refuses the write.
    for (int i = 0; i < 5; i++) cyc("refill", 1'b1, 1'b0, 1'b1, 32'h30 + 32'(i * 4));
    cyc("full_pop", 1'b1, 1'b0, 1'b0, 32'h44);
    chk("full_pop.addr", 64'(o_addr[1]), 64'h30);
    chk("full_pop.count", 64'(o_cnt[1]), 64'd3);
    chk("full_pop.ready", 64'(o_rdy[1]), 64'd1);

    // Jump flush drops the pair offered that cycle.
    cyc("jump", 1'b1, 1'b1, 1'b0, 32'h40);
    chk("jump.inst", 64'(o_inst[1]), 64'h13);
    chk("jump.count", 64'(o_cnt[1]), 64'd0);
    cyc("post_jump", 1'b0, 1'b0, 1'b0, 32'h0);
    chk("post_jump.valid", 64'(o_vld[1]), 64'd0);

    // Jump during hold.
    for (int i = 0; i < 3; i++) cyc("hold2", 1'b1, 1'b0, 1'b1, 32'h50 + 32'(i * 4));
    cyc("jump_hold", 1'b1, 1'b1, 1'b1, 32'h60);
    chk("jump_hold.addr", 64'(o_addr[1]), 64'h0);
    cyc("post_jump_hold", 1'b0, 1'b0, 1'b0, 32'h0);

    // Asynchronous reset between clock edges with two entries queued.
    for (int i = 0; i < 2; i++) cyc("pre_rst", 1'b1, 1'b0, 1'b1, 32'h70 + 32'(i * 4));
    chk("pre_rst.count", 64'(o_cnt[1]), 64'd2);
    bus0.rom_valid_i = 1'b0; bus1.rom_valid_i = 1'b0; bus2.rom_valid_i = 1'b0;
    hld = 1'b0;
    #3 rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #2 rst = 1'b1;
    cyc("after_rst", 1'b0, 1'b0, 1'b0, 32'h0);

    // Randomized traffic.
    pc = 32'h100;
    for (int i = 0; i < 300; i++) begin
      cyc("rand", ($urandom_range(3) != 0), ($urandom_range(11) == 0), ($urandom_range(3) == 0), pc);
      pc = pc + 32'd4;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
